// File: rtl/mod_inv_if.sv
// rtl/mod_inv_if.sv - operand/result handshake bundle for the modular inverter
interface mod_inv_if #(
   parameter int DATA_W = 23
) ();
   logic              in_valid_i;
   logic              in_ready_o;
   logic [DATA_W-1:0] a_i;
   logic              select_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] c_o;
   logic              zero_o;

   modport master (
      output in_valid_i, a_i, select_i, out_ready_i,
      input  in_ready_o, out_valid_o, c_o, zero_o
   );

   modport slave (
      input  in_valid_i, a_i, select_i, out_ready_i,
      output in_ready_o, out_valid_o, c_o, zero_o
   );
endinterface

// File: rtl/mod_inv.sv
// rtl/mod_inv.sv - Fermat modular inverter (a^(q-2) mod q) over a shared Barrett mod_mul
module mod_mul #(
   parameter int DATA_W      = 23,
   parameter int Q_KYBER     = 3329,
   parameter int Q_DILITHIUM = 8380417
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              select_i,
   output logic [DATA_W-1:0] c_o
);
   localparam int PW = 2 * DATA_W;
   localparam int EW = 2 * PW + 1;
   localparam logic [PW:0] MU_KYBER = (PW+1)'((64'd1 << PW) / 64'(Q_KYBER));
   localparam logic [PW:0] MU_DIL   = (PW+1)'((64'd1 << PW) / 64'(Q_DILITHIUM));

   logic [PW-1:0]   prod;
   logic [PW:0]     mu_sel;
   logic [PW:0]     q_wide;
   logic [PW:0]     qhat;
   logic [DATA_W:0] q_sel;
   logic [DATA_W:0] r;

   // Barrett estimate with k = 2*DATA_W never overshoots and undershoots by at most one q,
   // so a single conditional subtract finishes the reduction for any operands < 2^DATA_W.
   always_comb begin
      prod   = PW'(a_i) * PW'(b_i);
      mu_sel = select_i ? MU_KYBER : MU_DIL;
      q_sel  = select_i ? (DATA_W+1)'(Q_KYBER) : (DATA_W+1)'(Q_DILITHIUM);
      q_wide = (PW+1)'(q_sel);
      qhat   = (PW+1)'((EW'(prod) * EW'(mu_sel)) >> PW);
      r      = (DATA_W+1)'((PW+1)'(prod) - qhat * q_wide);
      c_o    = (r >= q_sel) ? DATA_W'(r - q_sel) : DATA_W'(r);
   end
endmodule

module mod_inv #(
   parameter int DATA_W      = 23,
   parameter int Q_KYBER     = 3329,
   parameter int Q_DILITHIUM = 8380417
) (
   input logic      clk_i,
   input logic      rst_ni,
   mod_inv_if.slave bus
);
   localparam int IDX_W   = $clog2(DATA_W);
   localparam int KYBER_W = $clog2(Q_KYBER);
   localparam int DIL_W   = $clog2(Q_DILITHIUM);
   localparam logic [DATA_W-1:0] E_KYBER   = DATA_W'(Q_KYBER - 2);
   localparam logic [DATA_W-1:0] E_DIL     = DATA_W'(Q_DILITHIUM - 2);
   localparam logic [IDX_W-1:0]  TOP_KYBER = IDX_W'(KYBER_W - 1);
   localparam logic [IDX_W-1:0]  TOP_DIL   = IDX_W'(DIL_W - 1);

   typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] a_reg;
   logic              sel_reg;
   logic [IDX_W-1:0]  bit_idx;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] c_q;
   logic              zero_q;

   logic [DATA_W-1:0] mm_b;
   logic [DATA_W-1:0] mm_c;
   logic [DATA_W-1:0] e_bits;
   logic              e_bit;
   logic              last_bit;

   always_comb begin
      mm_b     = (state == MUL) ? a_reg : acc;
      e_bits   = sel_reg ? E_KYBER : E_DIL;
      e_bit    = e_bits[bit_idx];
      last_bit = (bit_idx == '0);
   end

   mod_mul #(
      .DATA_W      (DATA_W),
      .Q_KYBER     (Q_KYBER),
      .Q_DILITHIUM (Q_DILITHIUM)
   ) u_mm (
      .a_i      (acc),
      .b_i      (mm_b),
      .select_i (sel_reg),
      .c_o      (mm_c)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         acc         <= '0;
         a_reg       <= '0;
         sel_reg     <= 1'b0;
         bit_idx     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         zero_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid_i) begin
                  a_reg      <= bus.select_i ? DATA_W'(bus.a_i[KYBER_W-1:0]) : bus.a_i;
                  sel_reg    <= bus.select_i;
                  acc        <= DATA_W'(1);
                  bit_idx    <= bus.select_i ? TOP_KYBER : TOP_DIL;
                  in_ready_q <= 1'b0;
                  state      <= SQR;
               end
            end
            SQR: begin
               acc <= mm_c;
               if (e_bit) begin
                  state <= MUL;
               end else if (last_bit) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  c_q         <= mm_c;
                  zero_q      <= (mm_c == '0);
               end else begin
                  bit_idx <= bit_idx - 1'b1;
               end
            end
            MUL: begin
               acc <= mm_c;
               if (last_bit) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  c_q         <= mm_c;
                  zero_q      <= (mm_c == '0);
               end else begin
                  bit_idx <= bit_idx - 1'b1;
                  state   <= SQR;
               end
            end
            DONE: begin
               // Result registers return to zero so c_o/zero_o read 0 outside DONE.
               if (bus.out_ready_i) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  c_q         <= '0;
                  zero_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.c_o         = c_q;
   assign bus.zero_o      = zero_q;
endmodule

// File: tb/tb_mod_inv.sv
// tb/tb_mod_inv.sv - self-checking bench for mod_inv: vector table, corner sequences, random ops
module tb_mod_inv;
   localparam int  DATA_W = 23;
   localparam longint QK  = 3329;
   localparam longint QD  = 8380417;

   logic clk_i = 1'b0;
   logic rst_ni;
   int   checks = 0;
   int   errors = 0;

   mod_inv_if #(.DATA_W(DATA_W)) bus ();

   mod_inv #(.DATA_W(DATA_W)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [22:0] a;
      logic        sel;
      logic [22:0] exp_c;
      logic        exp_z;
      int          exp_lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Extended Euclid: inverse of a mod q, 0 when a is 0 mod q.
   function automatic longint ref_inv(input longint a, input longint q);
      longint r0, r1, t0, t1, qt, tmp;
      r0 = q; r1 = a % q; t0 = 0; t1 = 1;
      if (r1 == 0) return 0;
      while (r1 != 0) begin
         qt = r0 / r1;
         tmp = r0 - qt * r1; r0 = r1; r1 = tmp;
         tmp = t0 - qt * t1; t0 = t1; t1 = tmp;
      end
      if (t0 < 0) t0 += q;
      return t0;
   endfunction

   task automatic wait_ready();
      int guard = 0;
      while (!bus.in_ready_o && guard < 200) begin
         @(posedge clk_i); #1; guard++;
      end
      chk("in_ready_before_op", 32'(bus.in_ready_o), 32'd1);
   endtask

   // Drives one operand, waits for the result, completes the handshake with out_ready_i=1.
   task automatic run_op(input logic [22:0] a, input logic sel, output logic [22:0] c,
                         output logic z, output int lat, output logic busy_ok);
      wait_ready();
      bus.a_i = a; bus.select_i = sel; bus.in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
      bus.a_i = 23'($urandom);
      bus.select_i = ~sel;
      lat = 0; busy_ok = 1'b1;
      while (!bus.out_valid_o && lat < 100) begin
         busy_ok = busy_ok & ~bus.in_ready_o;
         @(posedge clk_i); #1; lat++;
      end
      c = bus.c_o; z = bus.zero_o;
      @(posedge clk_i); #1;
   endtask

   vec_t        vecs[$];
   logic [22:0] c;
   logic        z;
   int          lat;
   logic        busy_ok;
   int          seen;

   initial begin
      rst_ni = 1'b0;
      bus.in_valid_i = 1'b0; bus.a_i = '0; bus.select_i = 1'b0; bus.out_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("reset_c", 32'(bus.c_o), 32'd0);
      chk("reset_zero", 32'(bus.zero_o), 32'd0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      vecs.push_back('{23'd2,       1'b1, 23'd1665,    1'b0, 22});
      vecs.push_back('{23'd3,       1'b1, 23'd1110,    1'b0, 22});
      vecs.push_back('{23'd1,       1'b1, 23'd1,       1'b0, 22});
      vecs.push_back('{23'd3328,    1'b1, 23'd3328,    1'b0, 22});
      vecs.push_back('{23'd3329,    1'b1, 23'd0,       1'b1, 22});
      vecs.push_back('{23'h7FF002,  1'b1, 23'd1665,    1'b0, 22});
      vecs.push_back('{23'd0,       1'b1, 23'd0,       1'b1, 22});
      vecs.push_back('{23'd2,       1'b0, 23'd4190209, 1'b0, 45});
      vecs.push_back('{23'd3,       1'b0, 23'd5586945, 1'b0, 45});
      vecs.push_back('{23'd8380416, 1'b0, 23'd8380416, 1'b0, 45});
      vecs.push_back('{23'd8380419, 1'b0, 23'd4190209, 1'b0, 45});
      vecs.push_back('{23'd0,       1'b0, 23'd0,       1'b1, 45});
      vecs.push_back('{23'd8380417, 1'b0, 23'd0,       1'b1, 45});

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].sel, c, z, lat, busy_ok);
         chk($sformatf("vec%0d_c", i), 32'(c), 32'(vecs[i].exp_c));
         chk($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp_z));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
         chk($sformatf("vec%0d_post_valid", i), 32'(bus.out_valid_o), 32'd0);
         chk($sformatf("vec%0d_post_c", i), 32'(bus.c_o), 32'd0);
      end

      // Backpressure in DONE while a new operand is offered.
      bus.out_ready_i = 1'b0;
      wait_ready();
      bus.a_i = 23'd2; bus.select_i = 1'b1; bus.in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
      lat = 0;
      while (!bus.out_valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
      chk("bp_latency", 32'(lat), 32'd22);
      bus.a_i = 23'd3; bus.select_i = 1'b1; bus.in_valid_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk_i); #1;
         chk("bp_hold_c", 32'(bus.c_o), 32'd1665);
         chk("bp_hold_valid", 32'(bus.out_valid_o), 32'd1);
         chk("bp_no_accept", 32'(bus.in_ready_o), 32'd0);
      end
      bus.out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("bp_idle_ready", 32'(bus.in_ready_o), 32'd1);
      chk("bp_valid_drop", 32'(bus.out_valid_o), 32'd0);
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
      chk("bp_accepted_next", 32'(bus.in_ready_o), 32'd0);
      lat = 0;
      while (!bus.out_valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
      chk("bp_second_c", 32'(bus.c_o), 32'd1110);
      chk("bp_second_latency", 32'(lat), 32'd22);
      @(posedge clk_i); #1;

      // Reset pulse in the middle of a Dilithium run.
      wait_ready();
      bus.a_i = 23'd5; bus.select_i = 1'b0; bus.in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
      repeat (10) begin @(posedge clk_i); #1; end
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("rst_mid_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_mid_c", 32'(bus.c_o), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      seen = 0;
      repeat (60) begin
         @(posedge clk_i); #1;
         if (bus.out_valid_o) seen++;
      end
      chk("rst_no_output", 32'(seen), 32'd0);
      run_op(23'd2, 1'b0, c, z, lat, busy_ok);
      chk("rst_after_c", 32'(c), 32'd4190209);
      chk("rst_after_latency", 32'(lat), 32'd45);

      // Random operands, modes alternating back to back.
      for (int i = 0; i < 2000; i++) begin
         logic [22:0] a;
         logic        sel;
         longint      q, am, expv;
         sel  = i[0];
         a    = 23'($urandom);
         q    = sel ? QK : QD;
         am   = sel ? longint'(a[11:0]) : longint'(a);
         expv = ref_inv(am, q);
         run_op(a, sel, c, z, lat, busy_ok);
         chk("rand_c", 32'(c), 32'(expv));
         chk("rand_zero", 32'(z), 32'((am % q) == 0));
         chk("rand_latency", 32'(lat), sel ? 32'd22 : 32'd45);
         chk("rand_busy", 32'(busy_ok), 32'd1);
         if ((am % q) != 0)
            chk("rand_product", 32'((longint'(c) * am) % q), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
